// File: rtl/c_drain_io_l3_out_serialize_c_m_axi_burst_fifo_pkg.sv
// Shared constants for the C-drain m_axi burst FIFO: storage style names and a
// constant-evaluable clog2 used to size count and pointer ports.
package c_drain_io_l3_out_serialize_c_m_axi_pkg;

  localparam string MS_AUTO     = "auto";
  localparam string MS_BLOCK    = "block";
  localparam string MS_DIST     = "distributed";
  localparam string MS_SHIFTREG = "shiftreg";

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/c_drain_io_l3_out_serialize_c_m_axi_burst_fifo_if.sv
// FIFO handshake bundle; the FIFO takes the slave view, the producer/consumer
// side takes the master view.
interface c_drain_io_l3_out_serialize_c_m_axi_burst_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CW         = 6
);
  logic                  if_full_n;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_empty_n;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic [CW-1:0]         if_num_data_valid;
  logic [CW-1:0]         if_num_free;
  logic                  if_almost_full;
  logic                  if_burst_rdy;

  modport slave (
    input  if_write, if_din, if_read,
    output if_full_n, if_empty_n, if_dout, if_num_data_valid, if_num_free,
           if_almost_full, if_burst_rdy
  );

  modport master (
    output if_write, if_din, if_read,
    input  if_full_n, if_empty_n, if_dout, if_num_data_valid, if_num_free,
           if_almost_full, if_burst_rdy
  );
endinterface

// File: rtl/c_drain_io_l3_out_serialize_c_m_axi_burst_mem.sv
// Simple dual-port storage with a registered read port; the read register doubles
// as the FIFO output register, so it carries a reset and a synchronous clear.
module c_drain_io_l3_out_serialize_c_m_axi_burst_mem
  import c_drain_io_l3_out_serialize_c_m_axi_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    SD         = 31,
  parameter int    AW         = 5,
  parameter string MEM_STYLE  = "auto"
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_raddr,
  input  logic                  i_clr,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0] r_q;

  if (MEM_STYLE == MS_SHIFTREG) begin : g_srl
    // Newest word at index 0; the caller addresses the oldest one directly.
    (* shreg_extract = "yes" *) logic [DATA_WIDTH-1:0] r_srl [SD];
    wire w_unused_waddr = ^i_waddr;
    always_ff @(posedge clk) begin
      if (i_we) begin
        r_srl[0] <= i_wdata;
        for (int i = 1; i < SD; i++) r_srl[i] <= r_srl[i-1];
      end
    end
    assign w_rd = r_srl[i_raddr];
  end else if (MEM_STYLE == MS_BLOCK) begin : g_block
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [SD];
    always_ff @(posedge clk) if (i_we) r_mem[i_waddr] <= i_wdata;
    assign w_rd = r_mem[i_raddr];
  end else if (MEM_STYLE == MS_DIST) begin : g_dist
    (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] r_mem [SD];
    always_ff @(posedge clk) if (i_we) r_mem[i_waddr] <= i_wdata;
    assign w_rd = r_mem[i_raddr];
  end else begin : g_auto
    logic [DATA_WIDTH-1:0] r_mem [SD];
    always_ff @(posedge clk) if (i_we) r_mem[i_waddr] <= i_wdata;
    assign w_rd = r_mem[i_raddr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_re)  r_q <= w_rd;
  end

  assign o_q = r_q;

endmodule

// File: rtl/c_drain_io_l3_out_serialize_c_m_axi_burst_fifo.sv
// First-word-fall-through burst FIFO for the C-drain m_axi path; DEPTH counts the
// output register. Optional synchronous flush via `C_DRAIN_M_AXI_FIFO_FLUSH_EN.
module c_drain_io_l3_out_serialize_c_m_axi_burst_fifo
  import c_drain_io_l3_out_serialize_c_m_axi_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 32,
  parameter string MEM_STYLE  = "auto",
  parameter int    AF_THRESH  = DEPTH - 4,
  parameter int    BURST_LEN  = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_en,
  c_drain_io_l3_out_serialize_c_m_axi_burst_fifo_if.slave bus
`ifdef C_DRAIN_M_AXI_FIFO_FLUSH_EN
  , input logic if_flush
`endif
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int SD = (DEPTH > 1) ? DEPTH - 1 : 1;
  localparam int AW = (SD > 1) ? clog2(SD) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] BL_C    = CW'(BURST_LEN);

  logic [CW-1:0] r_cnt, w_cnt_nxt, w_st_cnt;
  logic          r_out_vld, r_full_n, r_af, r_br;
  logic [AW-1:0] r_wptr, r_rptr, w_raddr;
  logic          w_push, w_pop, w_fetch, w_clr;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(SD - 1)) ? '0 : p + AW'(1);
  endfunction

  // Words still in storage, i.e. not yet moved into the output register.
  assign w_st_cnt = r_cnt - CW'(r_out_vld);
  assign w_push   = clk_en & bus.if_write & r_full_n;
  assign w_pop    = clk_en & bus.if_read & r_out_vld;
  assign w_fetch  = clk_en & (w_st_cnt != '0) & (~r_out_vld | bus.if_read);

`ifdef C_DRAIN_M_AXI_FIFO_FLUSH_EN
  assign w_clr = clk_en & if_flush;
`else
  assign w_clr = 1'b0;
`endif

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + CW'(1);
    else if (w_pop && !w_push) w_cnt_nxt = r_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_out_vld <= 1'b0;
      r_full_n  <= 1'b1;
      r_af      <= 1'b0;
      r_br      <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else if (w_clr) begin
      r_cnt     <= '0;
      r_out_vld <= 1'b0;
      r_full_n  <= 1'b1;
      r_af      <= 1'b0;
      r_br      <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else if (clk_en) begin
      // Flags come from the next count so they line up with r_cnt each cycle.
      r_cnt    <= w_cnt_nxt;
      r_full_n <= (w_cnt_nxt != DEPTH_C);
      r_af     <= (w_cnt_nxt >= AF_C);
      r_br     <= (w_cnt_nxt >= BL_C);
      if (w_push)  r_wptr <= f_inc(r_wptr);
      if (w_fetch) r_rptr <= f_inc(r_rptr);
      if (w_fetch)    r_out_vld <= 1'b1;
      else if (w_pop) r_out_vld <= 1'b0;
    end
  end

  if (MEM_STYLE == MS_SHIFTREG) begin : g_raddr_srl
    wire w_unused_rptr = ^r_rptr;
    assign w_raddr = AW'(w_st_cnt - CW'(1));
  end else begin : g_raddr_ram
    assign w_raddr = r_rptr;
  end

  c_drain_io_l3_out_serialize_c_m_axi_burst_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .SD         (SD),
    .AW         (AW),
    .MEM_STYLE  (MEM_STYLE)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (bus.if_din),
    .i_re    (w_fetch),
    .i_raddr (w_raddr),
    .i_clr   (w_clr),
    .o_q     (bus.if_dout)
  );

  assign bus.if_full_n         = r_full_n;
  assign bus.if_empty_n        = r_out_vld;
  assign bus.if_num_data_valid = r_cnt;
  assign bus.if_num_free       = DEPTH_C - r_cnt;
  assign bus.if_almost_full    = r_af;
  assign bus.if_burst_rdy      = r_br;

endmodule

// File: tb/tb_c_drain_io_l3_out_serialize_c_m_axi_burst_fifo.sv
// Directed bench: a DEPTH=32 shift-register FIFO and a DEPTH=5 RAM FIFO.
module tb_c_drain_io_l3_out_serialize_c_m_axi_burst_fifo;
  import c_drain_io_l3_out_serialize_c_m_axi_pkg::*;

  localparam int CW_A = clog2(33);
  localparam int CW_B = clog2(6);

  logic clk, reset_n, clk_en, flush_a, flush_b;
  int   n_chk, n_err, sent, rcv, cyc;

  c_drain_io_l3_out_serialize_c_m_axi_burst_fifo_if #(.DATA_WIDTH(32), .CW(CW_A)) bus_a ();
  c_drain_io_l3_out_serialize_c_m_axi_burst_fifo_if #(.DATA_WIDTH(32), .CW(CW_B)) bus_b ();

  c_drain_io_l3_out_serialize_c_m_axi_burst_fifo #(
    .DATA_WIDTH(32), .DEPTH(32), .MEM_STYLE("shiftreg"), .AF_THRESH(28), .BURST_LEN(16)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .bus(bus_a)
`ifdef C_DRAIN_M_AXI_FIFO_FLUSH_EN
    , .if_flush(flush_a)
`endif
  );

  c_drain_io_l3_out_serialize_c_m_axi_burst_fifo #(
    .DATA_WIDTH(32), .DEPTH(5), .MEM_STYLE("distributed"), .AF_THRESH(1), .BURST_LEN(3)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .bus(bus_b)
`ifdef C_DRAIN_M_AXI_FIFO_FLUSH_EN
    , .if_flush(flush_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    clk = 0; reset_n = 0; clk_en = 1; flush_a = 0; flush_b = 0;
    bus_a.if_write = 0; bus_a.if_read = 0; bus_a.if_din = '0;
    bus_b.if_write = 0; bus_b.if_read = 0; bus_b.if_din = '0;
    #12;
    chk("rst_full_n", 32'(bus_a.if_full_n), 1);
    chk("rst_empty_n", 32'(bus_a.if_empty_n), 0);
    chk("rst_cnt", 32'(bus_a.if_num_data_valid), 0);
    chk("rst_free", 32'(bus_a.if_num_free), 32);
    chk("rst_af", 32'(bus_a.if_almost_full), 0);
    chk("rst_br", 32'(bus_a.if_burst_rdy), 0);
    chk("rst_dout", bus_a.if_dout, 0);
    chk("rst_free_b", 32'(bus_b.if_num_free), 5);
    @(negedge clk);
    reset_n = 1;

    // first-word latency
    bus_a.if_write = 1; bus_a.if_din = 32'hA5;
    tick();
    bus_a.if_write = 0;
    chk("lat_empty_e1", 32'(bus_a.if_empty_n), 0);
    chk("lat_cnt_e1", 32'(bus_a.if_num_data_valid), 1);
    tick();
    chk("lat_empty_e2", 32'(bus_a.if_empty_n), 1);
    chk("lat_dout_e2", bus_a.if_dout, 32'hA5);
    chk("lat_cnt_e2", 32'(bus_a.if_num_data_valid), 1);
    bus_a.if_read = 1;
    tick();
    bus_a.if_read = 0;
    chk("lat_pop_empty", 32'(bus_a.if_empty_n), 0);
    chk("lat_pop_cnt", 32'(bus_a.if_num_data_valid), 0);

    // fill to full, refused writes, then drain in order
    for (int i = 0; i < 32; i++) begin
      bus_a.if_write = 1; bus_a.if_din = 32'h100 + 32'(i);
      tick();
      if (i == 26) chk("fill_af_27", 32'(bus_a.if_almost_full), 0);
      if (i == 27) chk("fill_af_28", 32'(bus_a.if_almost_full), 1);
      if (i == 30) chk("fill_full_n_31", 32'(bus_a.if_full_n), 1);
    end
    chk("fill_full_n_32", 32'(bus_a.if_full_n), 0);
    chk("fill_free_32", 32'(bus_a.if_num_free), 0);
    bus_a.if_din = 32'hDEAD;
    tick();
    chk("fill_33rd_cnt", 32'(bus_a.if_num_data_valid), 32);
    for (int i = 0; i < 32; i++) begin
      chk("drain_data", bus_a.if_dout, 32'h100 + 32'(i));
      bus_a.if_read = 1;
      bus_a.if_write = (i == 0);
      bus_a.if_din = 32'hBEEF;
      tick();
      if (i == 0) begin
        chk("full_rw_cnt", 32'(bus_a.if_num_data_valid), 31);
        chk("full_rw_full_n", 32'(bus_a.if_full_n), 1);
      end
    end
    bus_a.if_read = 0; bus_a.if_write = 0;
    chk("drain_empty", 32'(bus_a.if_empty_n), 0);
    chk("drain_cnt", 32'(bus_a.if_num_data_valid), 0);
    chk("drain_af", 32'(bus_a.if_almost_full), 0);

    // burst threshold and clock-enable freeze
    for (int i = 0; i < 16; i++) begin
      bus_a.if_write = 1; bus_a.if_din = 32'h200 + 32'(i);
      tick();
      if (i == 14) chk("burst_15", 32'(bus_a.if_burst_rdy), 0);
    end
    chk("burst_16", 32'(bus_a.if_burst_rdy), 1);
    clk_en = 0; bus_a.if_read = 1; bus_a.if_din = 32'h333;
    repeat (3) tick();
    chk("freeze_cnt", 32'(bus_a.if_num_data_valid), 16);
    chk("freeze_dout", bus_a.if_dout, 32'h200);
    chk("freeze_br", 32'(bus_a.if_burst_rdy), 1);
    clk_en = 1; bus_a.if_write = 0;
    tick();
    bus_a.if_read = 0;
    chk("burst_pop_br", 32'(bus_a.if_burst_rdy), 0);
    chk("burst_pop_dout", bus_a.if_dout, 32'h201);
    pulse_reset();

    // streaming 0..999
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 1000 && cyc < 1100) begin
      bus_a.if_write = (sent < 1000);
      bus_a.if_din = 32'(sent);
      bus_a.if_read = 1;
      if (bus_a.if_empty_n) begin
        chk("stream_data", bus_a.if_dout, 32'(rcv));
        rcv++;
      end
      if (bus_a.if_write) sent++;
      tick();
      cyc++;
      if (cyc >= 2 && sent < 1000) chk("stream_cnt", 32'(bus_a.if_num_data_valid), 2);
    end
    bus_a.if_write = 0; bus_a.if_read = 0;
    chk("stream_rcv", 32'(rcv), 1000);
    chk("stream_end_cnt", 32'(bus_a.if_num_data_valid), 0);

    // DEPTH=5: three fill/drain passes through the 4-entry storage
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        bus_b.if_write = 1; bus_b.if_din = 32'h50 + 32'(r * 8 + i);
        tick();
        if (i == 0) chk("b_af_1", 32'(bus_b.if_almost_full), 1);
        if (i == 1) chk("b_br_2", 32'(bus_b.if_burst_rdy), 0);
        if (i == 2) chk("b_br_3", 32'(bus_b.if_burst_rdy), 1);
      end
      bus_b.if_write = 0;
      chk("b_full_n", 32'(bus_b.if_full_n), 0);
      chk("b_free", 32'(bus_b.if_num_free), 0);
      for (int i = 0; i < 5; i++) begin
        chk("b_data", bus_b.if_dout, 32'h50 + 32'(r * 8 + i));
        bus_b.if_read = 1;
        tick();
      end
      bus_b.if_read = 0;
      chk("b_empty", 32'(bus_b.if_empty_n), 0);
    end
    for (int i = 0; i < 3; i++) begin
      bus_b.if_write = 1; bus_b.if_read = 1; bus_b.if_din = 32'h61 + 32'(i);
      tick();
    end
    chk("b_mid_dout", bus_b.if_dout, 32'h62);
    chk("b_mid_cnt", 32'(bus_b.if_num_data_valid), 2);
    #3;
    reset_n = 0;
    #1;
    chk("b_rst_full_n", 32'(bus_b.if_full_n), 1);
    chk("b_rst_empty_n", 32'(bus_b.if_empty_n), 0);
    chk("b_rst_cnt", 32'(bus_b.if_num_data_valid), 0);
    chk("b_rst_free", 32'(bus_b.if_num_free), 5);
    chk("b_rst_af", 32'(bus_b.if_almost_full), 0);
    chk("b_rst_br", 32'(bus_b.if_burst_rdy), 0);
    chk("b_rst_dout", bus_b.if_dout, 0);
    bus_b.if_write = 0; bus_b.if_read = 0;
    @(negedge clk);
    reset_n = 1;
    bus_b.if_write = 1; bus_b.if_din = 32'h77;
    tick();
    bus_b.if_write = 0;
    chk("b_post_e1", 32'(bus_b.if_empty_n), 0);
    tick();
    chk("b_post_e2", 32'(bus_b.if_empty_n), 1);
    chk("b_post_dout", bus_b.if_dout, 32'h77);
    chk("b_post_cnt", 32'(bus_b.if_num_data_valid), 1);

`ifdef C_DRAIN_M_AXI_FIFO_FLUSH_EN
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      bus_a.if_write = 1; bus_a.if_din = 32'h300 + 32'(i);
      tick();
    end
    chk("fl_cnt10", 32'(bus_a.if_num_data_valid), 10);
    flush_a = 1; bus_a.if_din = 32'hFF;
    tick();
    flush_a = 0; bus_a.if_write = 0;
    chk("fl_cnt", 32'(bus_a.if_num_data_valid), 0);
    chk("fl_empty", 32'(bus_a.if_empty_n), 0);
    chk("fl_dout", bus_a.if_dout, 0);
    chk("fl_free", 32'(bus_a.if_num_free), 32);
    tick();
    chk("fl_dropped", 32'(bus_a.if_empty_n), 0);
    chk("fl_dropped_cnt", 32'(bus_a.if_num_data_valid), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
